dmem_responder: RTL

- Data-memory target serving load/store requests issued by the core's data port: valid/ready request, valid/ready response.
- Holds DEPTH_WORDS x 32-bit words with byte/half/word access, sign/zero extension on loads, and a programmable wait-state count.
- Flags misaligned and out-of-range accesses with resp_err.
- Moves load-extension and byte-lane steering out of the core so the core can later stall on memory.

---
 rtl/dmem_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: byte/half/word data memory target with load extension and fault flagging; DMEM_CYCLE_COUNTER_EN maps a read-only cycle counter at 32'hFFFF_FFF0.
// Latency: resp_valid rises WAIT_CYCLES edges after the accept edge; at most one request per WAIT_CYCLES+2 cycles.
// Backpressure: req_ready stays low from accept until the response handshake; resp_rdata/resp_err hold stable while resp_ready is low.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);
   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] DEPTH_W   = 32'(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state, state_nx;
   logic [3:0]  wait_cnt;
   logic        lat_write, lat_unsigned;
   logic [31:0] lat_addr, lat_wdata;
   logic [1:0]  lat_size;

   logic        cur_write, cur_unsigned;
   logic [31:0] cur_addr, cur_wdata;
   logic [1:0]  cur_size;

   logic [32:0]   diff;
   logic [1:0]    lane;
   logic [AW-1:0] word_idx;
   logic          below_base, above_top, misaligned, illegal, acc_err;
   logic          enter_resp, commit;
   logic [31:0]   mem_word, ext_data, load_data, wd_lanes, new_word;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [3:0]    be;

   logic [31:0] mem [DEPTH_WORDS];

   // In IDLE the request is still on the inputs; it is needed directly when WAIT_CYCLES is 0.
   assign cur_write    = (state == S_IDLE) ? req_write    : lat_write;
   assign cur_addr     = (state == S_IDLE) ? req_addr     : lat_addr;
   assign cur_size     = (state == S_IDLE) ? req_size     : lat_size;
   assign cur_unsigned = (state == S_IDLE) ? req_unsigned : lat_unsigned;
   assign cur_wdata    = (state == S_IDLE) ? req_wdata    : lat_wdata;

   assign diff       = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
   assign below_base = diff[32];
   assign above_top  = {2'b00, diff[31:2]} >= DEPTH_W;
   assign lane       = diff[1:0];
   assign word_idx   = diff[AW+1:2];
   assign illegal    = (cur_size == 2'b11);
   assign misaligned = ((cur_size == 2'b01) && lane[0]) || ((cur_size == 2'b10) && (lane != 2'b00));

   assign mem_word = mem[word_idx];
   assign byte_sel = mem_word[{lane, 3'b000} +: 8];
   assign half_sel = lane[1] ? mem_word[31:16] : mem_word[15:0];

   always_comb begin
      ext_data = mem_word;
      wd_lanes = cur_wdata;
      be       = 4'b1111;
      case (cur_size)
         2'b00: begin
            ext_data = cur_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            wd_lanes = {4{cur_wdata[7:0]}};
            be       = 4'b0001 << lane;
         end
         2'b01: begin
            ext_data = cur_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            wd_lanes = {2{cur_wdata[15:0]}};
            be       = lane[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_comb begin
      new_word = mem_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) new_word[8*i +: 8] = wd_lanes[8*i +: 8];
      end
   end

`ifdef DMEM_CYCLE_COUNTER_EN
   logic [31:0] cycle_cnt;
   logic        is_ctr;

   always_ff @(posedge clk) begin
      if (reset) cycle_cnt <= '0;
      else       cycle_cnt <= cycle_cnt + 32'd1;
   end

   // The counter address skips the range check and only allows word loads.
   assign is_ctr    = (cur_addr == 32'hFFFF_FFF0);
   assign acc_err   = is_ctr ? (cur_write | (cur_size != 2'b10))
                             : (misaligned | illegal | below_base | above_top);
   assign load_data = is_ctr ? cycle_cnt : ext_data;
`else
   assign acc_err   = misaligned | illegal | below_base | above_top;
   assign load_data = ext_data;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (req_valid) state_nx = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
         S_WAIT:  if (wait_cnt == 4'd0) state_nx = S_RESP;
         S_RESP:  if (resp_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign enter_resp = ~reset && (state != S_RESP) && (state_nx == S_RESP);
   assign commit     = enter_resp && cur_write && ~acc_err;
   assign req_ready  = (state == S_IDLE) && ~reset;
   assign resp_valid = (state == S_RESP);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         wait_cnt   <= 4'd0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && req_valid) begin
            lat_write    <= req_write;
            lat_addr     <= req_addr;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_wdata    <= req_wdata;
            wait_cnt     <= WAIT_LOAD;
         end else if (state == S_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (enter_resp) begin
            resp_rdata <= (cur_write || acc_err) ? 32'd0 : load_data;
            resp_err   <= acc_err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (commit) mem[word_idx] <= new_word;
   end
endmodule
